// File: rtl/updown_pulse_gen.sv
// Paced up/down pulse generator with a registered mirror of the downstream counter.
// Latency: handshake at edge k gives the first pulse in cycle k+1 and done_o after the last pulse.
// Backpressure: req_ready_o is high only in IDLE, and requests are ignored while busy. Build option: CLAMP_EN (saturating mirror).
module updown_pulse_gen #(
  parameter int WID = 4,
  parameter int GAP = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic           req_dir_i,
  input  logic [WID-1:0] req_cnt_i,
  output logic           up_o,
  output logic           down_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           clamped_o,
  output logic [WID-1:0] mirror_o,
  output logic           full_o,
  output logic           empty_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // The gap counter runs 0..GAP-1 in WAIT. It keeps at least one bit so that GAP=0 still elaborates.
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t         state, state_nxt;
  logic [WID-1:0] remaining, remaining_nxt;
  logic [WID-1:0] mirror, mirror_nxt;
  logic           dir, dir_nxt;
  logic [GW-1:0]  gap_cnt, gap_cnt_nxt;

  // sat_now: the pulse of the current STEP cycle would overrun the mirror.
  // sat_nxt: the same test for the STEP cycle that is about to start.
  logic           sat_now;
  logic           sat_nxt;

  logic           up_q, down_q, done_q;

`ifdef CLAMP_EN
  logic           clamp_hit, clamp_hit_nxt;
  logic           clamped_q;

  assign sat_now = (state == STEP) && (dir ? (&mirror) : (mirror == '0));
  assign sat_nxt = (state_nxt == STEP) && (dir_nxt ? (&mirror_nxt) : (mirror_nxt == '0));
`else
  assign sat_now = 1'b0;
  assign sat_nxt = 1'b0;
`endif

  // State register and request/mirror bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      remaining <= '0;
      mirror    <= '0;
      dir       <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      mirror    <= mirror_nxt;
      dir       <= dir_nxt;
      gap_cnt   <= gap_cnt_nxt;
    end
  end

  // Next-state logic. The mirror moves at the edge that ends the pulse cycle.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    mirror_nxt    = mirror;
    dir_nxt       = dir;
    gap_cnt_nxt   = gap_cnt;
`ifdef CLAMP_EN
    clamp_hit_nxt = clamp_hit;
`endif
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          dir_nxt     = req_dir_i;
          gap_cnt_nxt = '0;
`ifdef CLAMP_EN
          clamp_hit_nxt = 1'b0;
`endif
          if (req_cnt_i == '0) begin
            remaining_nxt = '0;
            state_nxt     = DONE;
          end else begin
            remaining_nxt = req_cnt_i;
            state_nxt     = STEP;
          end
        end
      end
      STEP: begin
        if (sat_now) begin
          // The pulse is suppressed and the rest of the request is dropped.
          remaining_nxt = '0;
          state_nxt     = DONE;
`ifdef CLAMP_EN
          clamp_hit_nxt = 1'b1;
`endif
        end else begin
          remaining_nxt = remaining - 1'b1;
          mirror_nxt    = dir ? (mirror + 1'b1) : (mirror - 1'b1);
          gap_cnt_nxt   = '0;
          if (remaining == WID'(1)) begin
            state_nxt = DONE;
          end else if (GAP > 0) begin
            state_nxt = WAIT;
          end else begin
            state_nxt = STEP;
          end
        end
      end
      WAIT: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = STEP;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pulse and done flags are registered one edge ahead of the state they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      up_q   <= (state_nxt == STEP) && dir_nxt && !sat_nxt;
      down_q <= (state_nxt == STEP) && !dir_nxt && !sat_nxt;
      done_q <= (state_nxt == DONE);
    end
  end

`ifdef CLAMP_EN
  // The clamp flag is kept for the whole request and reported alongside done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clamp_hit <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      clamp_hit <= clamp_hit_nxt;
      clamped_q <= (state_nxt == DONE) && clamp_hit_nxt;
    end
  end

  assign clamped_o = clamped_q;
`else
  assign clamped_o = 1'b0;
`endif

  assign up_o        = up_q;
  assign down_o      = down_q;
  assign done_o      = done_q;
  assign busy_o      = (state != IDLE);
  assign req_ready_o = (state == IDLE);
  assign mirror_o    = mirror;
  assign full_o      = &mirror;
  assign empty_o     = (mirror == '0);

  // Structural invariants of the pulse outputs
  pulse_exclusive: assert property (@(posedge clk_i) disable iff (rst_i) !(up_o && down_o));
  pulse_in_busy:   assert property (@(posedge clk_i) disable iff (rst_i) (up_o || down_o) |-> busy_o);
  done_in_busy:    assert property (@(posedge clk_i) disable iff (rst_i) done_o |-> busy_o);

endmodule
